fruit_spawner: RTL and testbench
================================

# fruit_spawner

Responder for spawn requests from `update`: on a request it finds a random EMPTY cell of the tile map, writes the requested tile kind there through a read/write port into `mapa`, and reports the chosen coordinate. Random placement uses a free-running LFSR with rejection of occupied cells. After `MAX_TRIES` misses it falls back to a linear scan, so it fails only when the board is full. It sits between `update` (requester) and `mapa` (tile RAM) and replaces the fire-and-forget fruit path with a checked, handshaked one.

## Interface
Parameters:
- `MAPA_WIDTH`, 40, map columns
- `MAPA_HEIGHT`, 30, map rows
- `MAX_TRIES`, 64, random probes before the linear-scan fallback
- `SEED`, 16'hACE1, LFSR reset value; must be nonzero

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock, `CLOCK_50`
- `reset`  in  1  synchronous, active-high
- `spawn_req`  in  1  request, sampled only in IDLE
- `spawn_kind`  in  2  tile code to place, latched on accept
- `spawn_busy`  out  1  high from accept until the DONE/FAIL cycle inclusive
- `spawn_done`  out  1  1-cycle pulse, placement written
- `spawn_fail`  out  1  1-cycle pulse, no EMPTY cell exists
- `spawn_x`  out  10  column of the last successful placement
- `spawn_y`  out  10  row of the last successful placement
- `rd_en`  out  1  map read strobe
- `rx`  out  10  map read address, column
- `ry`  out  10  map read address, row
- `rdata`  in  2  tile at (`rx`,`ry`), valid the cycle after `rd_en`
- `we`  out  1  map write strobe
- `wx`  out  10  map write address, column
- `wy`  out  10  map write address, row
- `wdata`  out  2  tile code to write

## Operation
- Tile codes: EMPTY=0, COBRA=1, FRUTA=2, OBSTACULO=3.
- States: IDLE, PICK, READ, CHECK, WRITE, DONE, FAIL.
- IDLE: when `spawn_req`=1, latch `spawn_kind`, clear try counter and scan mode, go to PICK. A request while busy is ignored; no queueing.
- PICK, random mode:
  - Candidate x = `lfsr[XB-1:0]`, y = `lfsr[XB+YB-1:XB]`, where XB = $clog2(`MAPA_WIDTH`) and YB = $clog2(`MAPA_HEIGHT`).
  - If x ≥ `MAPA_WIDTH` or y ≥ `MAPA_HEIGHT`, stay in PICK; rejections do not count as tries.
  - Otherwise register the candidate and go to READ.
- PICK, scan mode: use the scan counter (x, y) directly and go to READ.
- READ: `rd_en`=1 with the candidate on `rx`/`ry`; go to CHECK.
- CHECK:
  - `rdata`==EMPTY → WRITE.
  - Otherwise, random mode: increment try counter; if it reaches `MAX_TRIES`, enter scan mode at (0,0), else go to PICK.
  - Otherwise, scan mode: advance x; wrap to 0 and increment y at `MAPA_WIDTH`-1; after (`MAPA_WIDTH`-1, `MAPA_HEIGHT`-1) go to FAIL, else go to PICK.
- WRITE: `we`=1, `wx`/`wy` = candidate, `wdata` = latched kind; update `spawn_x`/`spawn_y`; go to DONE.
- DONE / FAIL: pulse `spawn_done` / `spawn_fail`; go to IDLE. `spawn_x`/`spawn_y` are unchanged on FAIL.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It steps every cycle in every state, so placement depends on request timing.
- Shared-port rule: `update` must not access `mapa` while `spawn_busy`=1. `rx`/`ry`/`wx`/`wy` are don't-care when their strobes are low.

## Timing
- Reset: state IDLE, LFSR=`SEED`, all strobes and pulses 0, `spawn_busy`=0, `spawn_x`=`spawn_y`=0, counters 0.
- Reset mid-operation aborts immediately; no write is issued in or after the reset cycle.
- Best case, request seen at edge 0:
  - PICK in cycle 1, READ in cycle 2, CHECK in cycle 3.
  - `we` in cycle 4, `spawn_done` in cycle 5, IDLE in cycle 6.
- Each occupied probe adds 3 cycles, plus 1 cycle per rejection.
- Worst-case full board: FAIL ≈ 3·(`MAX_TRIES` + W·H) cycles plus rejections.
- `spawn_req` held high re-triggers on the IDLE cycle after DONE/FAIL.

## Structure
- `snake_pkg` holds the tile codes, `MAPA_WIDTH`/`MAPA_HEIGHT` defaults, `BLOCK_SIZE`, and the FSM state enum.
- One sub-module, `lfsr16`: inputs `clk`, `reset`, `SEED`; output `q[15:0]`; steps every cycle.

## Test plan
- Empty map model, reset, `spawn_req` pulse with kind=FRUTA → `we` at cycle 4 with an in-range (x,y) and `wdata`=2; `spawn_done` at cycle 5; `spawn_x`/`spawn_y` equal `wx`/`wy`.
- Map full except (17,9), `MAX_TRIES`=4, kind=OBSTACULO → after 4 misses scan finds (17,9); write with `wdata`=3; `spawn_done`=1.
- Fully occupied map → exactly one `spawn_fail` pulse, no `we` at any time, `spawn_x`/`spawn_y` unchanged, back to IDLE.
- `spawn_req` pulsed again during busy → ignored; exactly one `spawn_done` follows.
- Reset asserted the cycle after READ → no `we`, outputs at reset values next cycle; LFSR output equals `SEED` sequence again.
- 1000 requests on an empty map with the map cleared between requests → every (`wx`,`wy`) lies within 0..39 / 0..29 and at least 200 distinct cells are hit.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared map constants, tile codes, spawner FSM states and the LFSR step.
// Pure definitions; no timing or flow control of its own.
package snake_pkg;

  localparam int MAPA_WIDTH  = 40;
  localparam int MAPA_HEIGHT = 30;
  localparam int BLOCK_SIZE  = 16;
  localparam int COORD_W     = 10;

  typedef enum logic [1:0] {
    TILE_EMPTY     = 2'd0,
    TILE_COBRA     = 2'd1,
    TILE_FRUTA     = 2'd2,
    TILE_OBSTACULO = 2'd3
  } tile_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PICK,
    S_READ,
    S_CHECK,
    S_WRITE,
    S_DONE,
    S_FAIL
  } spawn_state_t;

  // Fibonacci taps 16,14,13,11 in right-shift form (feedback from bits 0,2,3,5).
  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    return {q[0] ^ q[2] ^ q[3] ^ q[5], q[15:1]};
  endfunction

endpackage

// File: rtl/fruit_spawner_if.sv
// Spawn request/response bundle and the tile-map read/write port.
// Wiring only; no latency or flow control of its own.
interface spawn_if;
  logic                          spawn_req;
  logic [1:0]                    spawn_kind;
  logic                          spawn_busy;
  logic                          spawn_done;
  logic                          spawn_fail;
  logic [snake_pkg::COORD_W-1:0] spawn_x;
  logic [snake_pkg::COORD_W-1:0] spawn_y;

  modport master (
    output spawn_req, spawn_kind,
    input  spawn_busy, spawn_done, spawn_fail, spawn_x, spawn_y
  );
  modport slave (
    input  spawn_req, spawn_kind,
    output spawn_busy, spawn_done, spawn_fail, spawn_x, spawn_y
  );
endinterface

interface mapa_if;
  logic                          rd_en;
  logic [snake_pkg::COORD_W-1:0] rx;
  logic [snake_pkg::COORD_W-1:0] ry;
  logic [1:0]                    rdata;
  logic                          we;
  logic [snake_pkg::COORD_W-1:0] wx;
  logic [snake_pkg::COORD_W-1:0] wy;
  logic [1:0]                    wdata;

  modport master (
    output rd_en, rx, ry, we, wx, wy, wdata,
    input  rdata
  );
  modport slave (
    input  rd_en, rx, ry, we, wx, wy, wdata,
    output rdata
  );
endinterface

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, loads SEED on reset.
// Latency: new value every cycle; no backpressure, it never stalls.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] q
);
  import snake_pkg::*;

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= SEED;
    end else begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/fruit_spawner.sv
// Places a tile on an EMPTY map cell: LFSR probes first, linear scan after MAX_TRIES misses.
// Latency: spawn_done 5 cycles after accept at best; requests while busy are dropped, never queued.
module fruit_spawner #(
  parameter int          MAPA_WIDTH  = snake_pkg::MAPA_WIDTH,
  parameter int          MAPA_HEIGHT = snake_pkg::MAPA_HEIGHT,
  parameter int          MAX_TRIES   = 64,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic   clk,
  input  logic   reset,
  spawn_if.slave spawn,
  mapa_if.master mapa
);
  import snake_pkg::*;

  localparam int XB    = $clog2(MAPA_WIDTH);
  localparam int YB    = $clog2(MAPA_HEIGHT);
  localparam int TRY_W = $clog2(MAX_TRIES + 1);

  localparam logic [COORD_W-1:0] X_LIM  = COORD_W'(MAPA_WIDTH);
  localparam logic [COORD_W-1:0] Y_LIM  = COORD_W'(MAPA_HEIGHT);
  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(MAPA_WIDTH - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(MAPA_HEIGHT - 1);
  localparam logic [TRY_W-1:0]   TRY_LAST = TRY_W'(MAX_TRIES - 1);

  spawn_state_t       state, state_d;
  logic [1:0]         kind_q, kind_d;
  logic [TRY_W-1:0]   try_cnt, try_d;
  logic               scan_mode, scan_d;
  logic [COORD_W-1:0] cand_x, cand_x_d, cand_y, cand_y_d;
  logic [COORD_W-1:0] scan_x, scan_x_d, scan_y, scan_y_d;
  logic [COORD_W-1:0] spawn_x_q, spawn_y_q;

  logic [15:0]        lfsr_q;
  logic [COORD_W-1:0] rnd_x, rnd_y;
  logic               rnd_ok;
  logic               lfsr_unused;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr_q)
  );

  assign rnd_x       = COORD_W'(lfsr_q[XB-1:0]);
  assign rnd_y       = COORD_W'(lfsr_q[XB+YB-1:XB]);
  assign rnd_ok      = (rnd_x < X_LIM) && (rnd_y < Y_LIM);
  assign lfsr_unused = ^lfsr_q[15:XB+YB];

  always_comb begin
    state_d  = state;
    kind_d   = kind_q;
    try_d    = try_cnt;
    scan_d   = scan_mode;
    cand_x_d = cand_x;
    cand_y_d = cand_y;
    scan_x_d = scan_x;
    scan_y_d = scan_y;

    case (state)
      S_IDLE: begin
        if (spawn.spawn_req) begin
          kind_d   = spawn.spawn_kind;
          try_d    = '0;
          scan_d   = 1'b0;
          scan_x_d = '0;
          scan_y_d = '0;
          state_d  = S_PICK;
        end
      end

      S_PICK: begin
        if (scan_mode) begin
          cand_x_d = scan_x;
          cand_y_d = scan_y;
          state_d  = S_READ;
        end else if (rnd_ok) begin
          cand_x_d = rnd_x;
          cand_y_d = rnd_y;
          state_d  = S_READ;
        end
      end

      S_READ: state_d = S_CHECK;

      S_CHECK: begin
        if (mapa.rdata == TILE_EMPTY) begin
          state_d = S_WRITE;
        end else if (!scan_mode) begin
          // The miss that exhausts the random budget hands over to the scan at (0,0).
          try_d   = try_cnt + TRY_W'(1);
          state_d = S_PICK;
          if (try_cnt == TRY_LAST) begin
            scan_d   = 1'b1;
            scan_x_d = '0;
            scan_y_d = '0;
          end
        end else if (scan_x == X_LAST && scan_y == Y_LAST) begin
          state_d = S_FAIL;
        end else begin
          state_d = S_PICK;
          if (scan_x == X_LAST) begin
            scan_x_d = '0;
            scan_y_d = scan_y + COORD_W'(1);
          end else begin
            scan_x_d = scan_x + COORD_W'(1);
          end
        end
      end

      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      S_FAIL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      kind_q    <= '0;
      try_cnt   <= '0;
      scan_mode <= 1'b0;
      cand_x    <= '0;
      cand_y    <= '0;
      scan_x    <= '0;
      scan_y    <= '0;
      spawn_x_q <= '0;
      spawn_y_q <= '0;
    end else begin
      state     <= state_d;
      kind_q    <= kind_d;
      try_cnt   <= try_d;
      scan_mode <= scan_d;
      cand_x    <= cand_x_d;
      cand_y    <= cand_y_d;
      scan_x    <= scan_x_d;
      scan_y    <= scan_y_d;
      if (state == S_WRITE) begin
        spawn_x_q <= cand_x;
        spawn_y_q <= cand_y;
      end
    end
  end

  // Strobes are masked by reset so an abort never leaks a write in the reset cycle.
  assign spawn.spawn_busy = (state != S_IDLE)  && !reset;
  assign spawn.spawn_done = (state == S_DONE)  && !reset;
  assign spawn.spawn_fail = (state == S_FAIL)  && !reset;
  assign spawn.spawn_x    = spawn_x_q;
  assign spawn.spawn_y    = spawn_y_q;

  assign mapa.rd_en = (state == S_READ)  && !reset;
  assign mapa.rx    = cand_x;
  assign mapa.ry    = cand_y;
  assign mapa.we    = (state == S_WRITE) && !reset;
  assign mapa.wx    = cand_x;
  assign mapa.wy    = cand_y;
  assign mapa.wdata = kind_q;

endmodule

// File: tb/tb_fruit_spawner.sv
// Bench for fruit_spawner: behavioural tile RAM, reference LFSR and a placement predictor.
module tb_fruit_spawner;
  localparam int          W     = 40;
  localparam int          H     = 30;
  localparam int          TRIES = 4;
  localparam logic [15:0] SEED  = 16'hACE1;
  localparam int          XSPAN = 1 << $clog2(W);
  localparam int          YSPAN = 1 << $clog2(H);

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  spawn_if sp();
  mapa_if  mp();

  fruit_spawner #(
    .MAPA_WIDTH  (W),
    .MAPA_HEIGHT (H),
    .MAX_TRIES   (TRIES),
    .SEED        (SEED)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .spawn (sp),
    .mapa  (mp)
  );

  int errors = 0;
  int checks = 0;

  // Tile RAM model with a one-cycle registered read.
  logic [1:0] tiles [H][W];
  logic [1:0] rdata_q;
  int         we_count = 0;
  assign mp.rdata = rdata_q;

  always @(posedge clk) begin
    if (mp.rd_en && mp.rx < W && mp.ry < H) rdata_q <= tiles[int'(mp.ry)][int'(mp.rx)];
    if (mp.we) begin
      if (mp.wx < W && mp.wy < H) tiles[int'(mp.wy)][int'(mp.wx)] = mp.wdata;
      we_count = we_count + 1;
    end
  end

  function automatic logic [15:0] ref_step(input logic [15:0] v);
    int b;
    b = (v ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 1;
    return 16'((v >> 1) | (b << 15));
  endfunction

  logic [15:0] m_lfsr;
  always @(posedge clk) m_lfsr <= reset ? SEED : ref_step(m_lfsr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Predicts placement from the LFSR value in the first PICK cycle (cycle 1 after accept).
  function automatic void predict(input logic [15:0] v0, output bit pfail,
                                  output int px, output int py, output int pcyc);
    logic [15:0] v;
    int t, tries, x, y;
    v = v0; t = 1; tries = 0; pfail = 0; px = -1; py = -1; pcyc = 0;
    while (tries < TRIES) begin
      x = int'(v) % XSPAN;
      y = (int'(v) / XSPAN) % YSPAN;
      if (x >= W || y >= H) begin
        v = ref_step(v); t = t + 1;
      end else if (tiles[y][x] == 2'd0) begin
        px = x; py = y; pcyc = t + 3; return;
      end else begin
        tries++; v = ref_step(ref_step(ref_step(v))); t = t + 3;
      end
    end
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++) begin
        if (tiles[yy][xx] == 2'd0) begin
          px = xx; py = yy; pcyc = t + 3; return;
        end
        t = t + 3;
      end
    pfail = 1; pcyc = t;
  endfunction

  task automatic fill_map(input bit full);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        tiles[y][x] = full ? 2'($urandom_range(3, 1)) : 2'd0;
  endtask

  int last_x, last_y;

  task automatic do_spawn(input logic [1:0] kind, input bit poke_busy, input string tag);
    logic [15:0] v;
    bit pf;
    int px, py, pc, sx0, sy0;
    int n_we, n_done, n_fail, we_cyc, end_cyc, wxs, wys, wds, extra;
    bit finished;
    n_we = 0; n_done = 0; n_fail = 0; we_cyc = -1; end_cyc = -1;
    wxs = -1; wys = -1; wds = -1; extra = 0; finished = 0;
    @(negedge clk);
    sx0 = int'(sp.spawn_x); sy0 = int'(sp.spawn_y);
    sp.spawn_req = 1'b1; sp.spawn_kind = kind;
    @(posedge clk);
    #1 sp.spawn_req = 1'b0;
    v = m_lfsr;
    predict(v, pf, px, py, pc);
    for (int c = 1; c <= 6000; c++) begin
      @(negedge clk);
      if (poke_busy && c == 2) sp.spawn_req = 1'b1;
      if (poke_busy && c == 3) sp.spawn_req = 1'b0;
      if (c == 1) check({tag, " busy_after_accept"}, 32'(sp.spawn_busy), 1);
      if (mp.we) begin
        n_we++; we_cyc = c; wxs = int'(mp.wx); wys = int'(mp.wy); wds = int'(mp.wdata);
      end
      if (sp.spawn_done) n_done++;
      if (sp.spawn_fail) n_fail++;
      if (n_done + n_fail > 0) begin
        end_cyc = c; finished = 1;
        break;
      end
    end
    check({tag, " finished"}, 32'(finished), 1);
    check({tag, " fail_flag"}, 32'(n_fail), 32'(pf));
    check({tag, " end_cycle"}, 32'(end_cyc), pf ? 32'(pc) : 32'(pc + 1));
    if (!pf) begin
      check({tag, " we_count"}, 32'(n_we), 1);
      check({tag, " we_cycle"}, 32'(we_cyc), 32'(pc));
      check({tag, " wx"}, 32'(wxs), 32'(px));
      check({tag, " wy"}, 32'(wys), 32'(py));
      check({tag, " wdata"}, 32'(wds), 32'(kind));
      check({tag, " spawn_x"}, 32'(sp.spawn_x), 32'(px));
      check({tag, " spawn_y"}, 32'(sp.spawn_y), 32'(py));
      check({tag, " in_range"}, 32'(wxs >= 0 && wxs < W && wys >= 0 && wys < H), 1);
    end else begin
      check({tag, " no_write"}, 32'(n_we), 0);
      check({tag, " spawn_x_kept"}, 32'(sp.spawn_x), 32'(sx0));
      check({tag, " spawn_y_kept"}, 32'(sp.spawn_y), 32'(sy0));
    end
    @(negedge clk);
    check({tag, " idle_after"}, 32'(sp.spawn_busy), 0);
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      extra += int'(sp.spawn_done) + int'(sp.spawn_fail) + int'(mp.we);
    end
    check({tag, " no_extra_pulses"}, 32'(extra), 0);
    last_x = px; last_y = py;
  endtask

  bit hit [H][W];
  int distinct, start_we;

  initial begin
    sp.spawn_req = 1'b0;
    sp.spawn_kind = 2'd0;
    fill_map(0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset busy", 32'(sp.spawn_busy), 0);
    check("reset done", 32'(sp.spawn_done), 0);
    check("reset fail", 32'(sp.spawn_fail), 0);
    check("reset we", 32'(mp.we), 0);
    check("reset rd_en", 32'(mp.rd_en), 0);
    check("reset spawn_x", 32'(sp.spawn_x), 0);
    check("reset spawn_y", 32'(sp.spawn_y), 0);

    do_spawn(2'd2, 0, "empty_fruta");
    do_spawn(2'd1, 1, "busy_poke");

    fill_map(1);
    tiles[9][17] = 2'd0;
    do_spawn(2'd3, 0, "one_hole");
    check("one_hole cell", 32'(last_x * 100 + last_y), 32'(17 * 100 + 9));
    check("one_hole written", 32'(tiles[9][17]), 3);

    fill_map(1);
    start_we = we_count;
    do_spawn(2'd2, 0, "full_board");
    check("full_board outcome", 32'(last_x), 32'(-1));
    check("full_board no_we", 32'(we_count - start_we), 0);

    // Abort in the CHECK cycle: the write that would follow must never happen.
    fill_map(0);
    @(negedge clk);
    sp.spawn_req = 1'b1; sp.spawn_kind = 2'd2;
    @(posedge clk);
    #1 sp.spawn_req = 1'b0;
    start_we = we_count;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (mp.rd_en) break;
    end
    check("abort saw_read", 32'(mp.rd_en), 1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("abort we_in_reset", 32'(mp.we), 0);
    check("abort busy_in_reset", 32'(sp.spawn_busy), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort busy", 32'(sp.spawn_busy), 0);
    check("abort spawn_x", 32'(sp.spawn_x), 0);
    check("abort spawn_y", 32'(sp.spawn_y), 0);
    repeat (5) @(negedge clk);
    check("abort no_write", 32'(we_count - start_we), 0);
    do_spawn(2'd1, 0, "after_abort");

    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) hit[y][x] = 0;
    for (int i = 0; i < 1000; i++) begin
      fill_map(0);
      repeat ($urandom_range(3, 0)) @(negedge clk);
      do_spawn(2'($urandom_range(3, 1)), 0, "random");
      if (last_x >= 0 && last_x < W && last_y >= 0 && last_y < H) hit[last_y][last_x] = 1;
    end
    distinct = 0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) distinct += int'(hit[y][x]);
    check("random distinct>=200", 32'(distinct >= 200), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
